// File: rtl/jtdd_mcu_com.sv
// MCU-side end of the main CPU <-> MCU link in the Double Dragon core.
// Holds the shared communication RAM and sequences the halt/bus-grant
// handshake. It also carries the NMI to the MCU and the IRQ pulse back
// to the main CPU.
module jtdd_mcu_com #(
  parameter int AW   = 9,
  parameter int IRQW = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          main_cen,
  input  logic          mcu_cen,
  // main CPU side
  input  logic          main_cs,
  input  logic [AW-1:0] main_addr,
  input  logic          main_rnw,
  input  logic [7:0]    main_din,
  output logic [7:0]    main_dout,
  input  logic          main_nmi_set,
  input  logic          main_halt,
  output logic          main_ban,
  output logic          main_irq,
  // MCU side
  input  logic          mcu_cs,
  input  logic [AW-1:0] mcu_addr,
  input  logic          mcu_wr,
  input  logic [7:0]    mcu_din,
  output logic [7:0]    mcu_dout,
  input  logic          mcu_busy,
  input  logic          mcu_irqmain_cs,
  input  logic          mcu_nmi_ack,
  output logic          mcu_nmi,
  output logic          mcu_haltn
);

  localparam int         DEPTH    = 1 << AW;
  localparam logic [3:0] IRQ_LOAD = 4'(IRQW);

  typedef enum logic [1:0] {
    RUN,
    HALT_REQ,
    HALTED
  } state_t;

  state_t     state;
  logic [7:0] mem [0:DEPTH-1];
  logic [3:0] irq_cnt;
  logic       mcu_we;
  logic       main_we;

  // The MCU is frozen while halted, so any write it presents then is stale.
  assign mcu_we  = mcu_cen & mcu_cs & mcu_wr & (state != HALTED);
  // The main CPU only owns the RAM once the bus has been granted.
  assign main_we = main_cen & main_cs & ~main_rnw & main_ban;

  // Shared RAM writes; the main port is written last so it wins a collision.
  // NOTE: the RAM array has no reset branch so it maps onto block RAM;
  // its contents survive rst.
  always_ff @(posedge clk) begin
    if (mcu_we)  mem[mcu_addr]  <= mcu_din;
    if (main_we) mem[main_addr] <= main_din;
  end

  // MCU read port, registered one clk behind mcu_cs.
  always_ff @(posedge clk) begin
    if (rst)         mcu_dout <= 8'h00;
    else if (mcu_cs) mcu_dout <= mem[mcu_addr];
  end

  // Main read port; the bus floats high (8'hFF) without a grant.
  always_ff @(posedge clk) begin
    if (rst)          main_dout <= 8'hFF;
    else if (main_cs) main_dout <= main_ban ? mem[main_addr] : 8'hFF;
  end

  // Halt handshake FSM; outputs change together with the state.
  // NOTE: state and outputs use non-blocking assignments so every
  // register in this block sees the values from before the edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= RUN;
      main_ban  <= 1'b0;
      mcu_haltn <= 1'b1;
    end else begin
      case (state)
        RUN: begin
          if (main_halt) begin
            state     <= HALT_REQ;
            mcu_haltn <= 1'b0;
          end
        end
        HALT_REQ: begin
          if (!main_halt) begin
            state     <= RUN;
            mcu_haltn <= 1'b1;
          end else if (mcu_cen && !mcu_busy) begin
            state    <= HALTED;
            main_ban <= 1'b1;
          end
        end
        HALTED: begin
          if (!main_halt) begin
            state     <= RUN;
            main_ban  <= 1'b0;
            mcu_haltn <= 1'b1;
          end
        end
        default: begin
          state     <= RUN;
          main_ban  <= 1'b0;
          mcu_haltn <= 1'b1;
        end
      endcase
    end
  end

  // NMI pending flag: a main-side set beats an MCU ack in the same clk.
  always_ff @(posedge clk) begin
    if (rst)                              mcu_nmi <= 1'b0;
    else if (main_cen && main_nmi_set)    mcu_nmi <= 1'b1;
    else if (mcu_cen && mcu_nmi_ack)      mcu_nmi <= 1'b0;
  end

  // IRQ to main: a reload counter clocked by main_cen. A retrigger only
  // stretches the pulse and never creates a second edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      irq_cnt  <= 4'd0;
      main_irq <= 1'b0;
    end else if (mcu_cen && mcu_irqmain_cs) begin
      irq_cnt  <= IRQ_LOAD;
      main_irq <= 1'b1;
    end else if (main_cen && irq_cnt != 4'd0) begin
      irq_cnt  <= irq_cnt - 4'd1;
      main_irq <= (irq_cnt != 4'd1);
    end
  end

endmodule

// File: tb/tb_jtdd_mcu_com.sv
// Self-checking bench for jtdd_mcu_com. RAM reads are checked through a
// scoreboard queue against a small RAM model. Handshake, NMI and IRQ
// outputs are compared against constants known from the behaviour.
module tb_jtdd_mcu_com;

  localparam int AW = 9;

  logic          clk = 1'b0;
  logic          rst;
  logic          main_cen, mcu_cen;
  logic          main_cs, main_rnw, main_nmi_set, main_halt;
  logic [AW-1:0] main_addr;
  logic [7:0]    main_din, main_dout;
  logic          main_ban, main_irq;
  logic          mcu_cs, mcu_wr, mcu_busy, mcu_irqmain_cs, mcu_nmi_ack;
  logic [AW-1:0] mcu_addr;
  logic [7:0]    mcu_din, mcu_dout;
  logic          mcu_nmi, mcu_haltn;

  jtdd_mcu_com #(.AW(AW), .IRQW(4)) dut (
    .clk            (clk),
    .rst            (rst),
    .main_cen       (main_cen),
    .mcu_cen        (mcu_cen),
    .main_cs        (main_cs),
    .main_addr      (main_addr),
    .main_rnw       (main_rnw),
    .main_din       (main_din),
    .main_dout      (main_dout),
    .main_nmi_set   (main_nmi_set),
    .main_halt      (main_halt),
    .main_ban       (main_ban),
    .main_irq       (main_irq),
    .mcu_cs         (mcu_cs),
    .mcu_addr       (mcu_addr),
    .mcu_wr         (mcu_wr),
    .mcu_din        (mcu_din),
    .mcu_dout       (mcu_dout),
    .mcu_busy       (mcu_busy),
    .mcu_irqmain_cs (mcu_irqmain_cs),
    .mcu_nmi_ack    (mcu_nmi_ack),
    .mcu_nmi        (mcu_nmi),
    .mcu_haltn      (mcu_haltn)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit         is_mcu;
    logic [7:0] val;
    string      tag;
  } exp_t;

  exp_t       exp_q[$];
  logic [7:0] model [0:(1<<AW)-1];
  bit         granted;
  int         checks   = 0;
  int         failures = 0;
  int         cyc      = 0;
  int         irq_ticks;
  int         irq_rises;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One clock: inputs were set after the previous edge. The IRQ pulse is
  // measured by counting main_cen edges seen while main_irq is high.
  task automatic tick();
    logic prev_irq;
    prev_irq = main_irq;
    if (main_cen && main_irq === 1'b1) irq_ticks++;
    @(posedge clk);
    #1;
    cyc++;
    if (main_irq === 1'b1 && prev_irq !== 1'b1) irq_rises++;
  endtask

  task automatic mcu_write(input logic [AW-1:0] a, input logic [7:0] d);
    mcu_cs = 1'b1; mcu_wr = 1'b1; mcu_addr = a; mcu_din = d; mcu_cen = 1'b1;
    tick();
    mcu_cs = 1'b0; mcu_wr = 1'b0;
    if (!granted) model[a] = d;
  endtask

  task automatic main_write(input logic [AW-1:0] a, input logic [7:0] d);
    main_cs = 1'b1; main_rnw = 1'b0; main_addr = a; main_din = d; main_cen = 1'b1;
    tick();
    main_cs = 1'b0; main_rnw = 1'b1;
    if (granted) model[a] = d;
  endtask

  task automatic mcu_read(input logic [AW-1:0] a, input string tag);
    exp_t e;
    mcu_cs = 1'b1; mcu_wr = 1'b0; mcu_addr = a;
    exp_q.push_back('{is_mcu: 1'b1, val: model[a], tag: tag});
    tick();
    mcu_cs = 1'b0;
    e = exp_q.pop_front();
    check(e.tag, {24'd0, mcu_dout}, {24'd0, e.val});
  endtask

  task automatic main_read(input logic [AW-1:0] a, input string tag);
    exp_t e;
    main_cs = 1'b1; main_rnw = 1'b1; main_addr = a;
    exp_q.push_back('{is_mcu: 1'b0, val: granted ? model[a] : 8'hFF, tag: tag});
    tick();
    main_cs = 1'b0;
    e = exp_q.pop_front();
    check(e.tag, {24'd0, main_dout}, {24'd0, e.val});
  endtask

  task automatic irq_trigger();
    main_cen = 1'b0; mcu_cen = 1'b1; mcu_irqmain_cs = 1'b1;
    tick();
    mcu_irqmain_cs = 1'b0;
  endtask

  task automatic irq_run(input int n);
    for (int i = 0; i < n; i++) begin
      main_cen = (cyc % 4 == 0);
      tick();
    end
  endtask

  initial begin
    rst = 1'b1; main_cen = 1'b1; mcu_cen = 1'b1;
    main_cs = 1'b0; main_rnw = 1'b1; main_addr = '0; main_din = 8'h00;
    main_nmi_set = 1'b0; main_halt = 1'b0;
    mcu_cs = 1'b0; mcu_wr = 1'b0; mcu_addr = '0; mcu_din = 8'h00;
    mcu_busy = 1'b0; mcu_irqmain_cs = 1'b0; mcu_nmi_ack = 1'b0;
    granted = 1'b0; irq_ticks = 0; irq_rises = 0;
    tick(); tick();
    check("rst_main_dout", {24'd0, main_dout}, 32'hFF);
    check("rst_mcu_dout",  {24'd0, mcu_dout},  32'h00);
    check("rst_main_ban",  {31'd0, main_ban},  32'd0);
    check("rst_main_irq",  {31'd0, main_irq},  32'd0);
    check("rst_mcu_nmi",   {31'd0, mcu_nmi},   32'd0);
    check("rst_mcu_haltn", {31'd0, mcu_haltn}, 32'd1);
    rst = 1'b0;
    tick();

    // MCU fills a few locations, including the top of the address space.
    mcu_write(9'h1FF, 8'h5A);
    mcu_write(9'h000, 8'h77);
    mcu_write(9'h020, 8'h11);
    mcu_read(9'h1FF, "mcu_rd_1ff");
    mcu_read(9'h000, "mcu_rd_000");

    // Without a bus grant, main writes are dropped and reads return FF.
    main_write(9'h020, 8'h3C);
    main_read(9'h020, "main_rd_noban");
    mcu_read(9'h020, "mcu_rd_after_dropped_wr");

    // Halt request held off by a busy MCU for three mcu_cen ticks.
    main_halt = 1'b1; mcu_busy = 1'b1;
    tick();
    check("haltreq_haltn", {31'd0, mcu_haltn}, 32'd0);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("busy_no_ban", {31'd0, main_ban}, 32'd0);
    end
    mcu_cen = 1'b0; mcu_busy = 1'b0;
    tick();
    check("nocen_no_ban", {31'd0, main_ban}, 32'd0);
    mcu_cen = 1'b1;
    tick();
    check("ban_rise", {31'd0, main_ban}, 32'd1);
    check("halted_haltn", {31'd0, mcu_haltn}, 32'd0);
    granted = 1'b1;

    // Granted main accesses; MCU writes while halted must not land.
    mcu_write(9'h000, 8'hEE);
    main_write(9'h010, 8'hA5);
    main_read(9'h010, "main_rd_010");
    main_read(9'h1FF, "main_rd_1ff");
    main_read(9'h000, "main_rd_000");

    main_halt = 1'b0;
    tick();
    granted = 1'b0;
    check("release_ban", {31'd0, main_ban}, 32'd0);
    check("release_haltn", {31'd0, mcu_haltn}, 32'd1);

    // Reset while HALTED with main_halt held high.
    main_halt = 1'b1;
    tick(); tick();
    check("rehalt_ban", {31'd0, main_ban}, 32'd1);
    rst = 1'b1;
    tick();
    check("rst_halted_ban", {31'd0, main_ban}, 32'd0);
    check("rst_halted_haltn", {31'd0, mcu_haltn}, 32'd1);
    check("rst_halted_dout", {24'd0, main_dout}, 32'hFF);
    rst = 1'b0;
    tick();
    check("post_rst_haltreq", {31'd0, mcu_haltn}, 32'd0);
    check("post_rst_no_ban", {31'd0, main_ban}, 32'd0);
    tick();
    check("post_rst_ban", {31'd0, main_ban}, 32'd1);
    main_halt = 1'b0;
    tick();
    mcu_read(9'h1FF, "ram_kept_over_rst");

    // NMI: set wins over a simultaneous ack; ack needs mcu_cen.
    main_cen = 1'b1; mcu_cen = 1'b1; main_nmi_set = 1'b1;
    tick();
    check("nmi_set", {31'd0, mcu_nmi}, 32'd1);
    mcu_nmi_ack = 1'b1;
    tick();
    check("nmi_set_wins", {31'd0, mcu_nmi}, 32'd1);
    main_nmi_set = 1'b0; mcu_cen = 1'b0;
    tick();
    check("nmi_ack_nocen", {31'd0, mcu_nmi}, 32'd1);
    mcu_cen = 1'b1;
    tick();
    check("nmi_ack", {31'd0, mcu_nmi}, 32'd0);
    mcu_nmi_ack = 1'b0;

    // IRQ: single pulse over four main_cen ticks.
    irq_ticks = 0; irq_rises = 0;
    irq_trigger();
    check("irq_rise", {31'd0, main_irq}, 32'd1);
    irq_run(60);
    check("irq_ticks_single", irq_ticks, 4);
    check("irq_rises_single", irq_rises, 1);
    check("irq_low_after", {31'd0, main_irq}, 32'd0);

    // IRQ retrigger after two ticks stretches the pulse to six.
    irq_ticks = 0; irq_rises = 0;
    irq_trigger();
    for (int i = 0; i < 100; i++) begin
      if (irq_ticks >= 2) break;
      irq_run(1);
    end
    check("irq_reach_two", irq_ticks, 2);
    irq_trigger();
    irq_run(60);
    check("irq_ticks_retrig", irq_ticks, 6);
    check("irq_rises_retrig", irq_rises, 1);
    check("irq_low_end", {31'd0, main_irq}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
